// File: rtl/interrupt_ack_sequencer.sv
// 8259A control core: INT/INTA sequencing, in-service register,
// EOI handling and priority rotation.
module interrupt_ack_sequencer #(
  parameter int NUM_IRQ = 8,
  parameter int LVL_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt,
  input  logic               inta_strobe,
  input  logic               mode_8086,
  input  logic               auto_eoi,
  input  logic               auto_rotate,
  input  logic [4:0]         vector_base,
  input  logic [2:0]         call_addr_lo,
  input  logic [7:0]         call_addr_hi,
  input  logic               eoi_cmd,
  input  logic               eoi_specific,
  input  logic [LVL_W-1:0]   eoi_level,
  input  logic               eoi_rotate,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] isr,
  output logic [LVL_W-1:0]   priority_rotate,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic               ack_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACK2,
    ACK3
  } state_t;

  state_t             state_q, state_d;
  logic               int_q, int_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [LVL_W-1:0]   rot_q, rot_d;
  logic [7:0]         dout_q, dout_d;
  logic               dval_q, dval_d;
  logic               busy_q;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               spur_q, spur_d;

  logic [NUM_IRQ-1:0] set_v;
  logic [NUM_IRQ-1:0] clr_v;
  logic               last_ack;
  logic [LVL_W-1:0]   enc;
  logic [LVL_W-1:0]   idx;
  logic               found;

  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (interrupt[i]) enc = LVL_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    rot_d    = rot_q;
    dout_d   = dout_q;
    dval_d   = 1'b0;
    lvl_d    = lvl_q;
    spur_d   = spur_q;
    set_v    = '0;
    clr_v    = '0;
    last_ack = 1'b0;
    idx      = '0;
    found    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|interrupt) begin
          state_d = ARMED;
          int_d   = 1'b1;
        end
      end
      ARMED: begin
        if (inta_strobe) begin
          spur_d  = ~|interrupt;
          lvl_d   = (~|interrupt) ? '1 : enc;
          set_v   = interrupt;
          int_d   = 1'b0;
          state_d = ACK2;
          if (!mode_8086) begin
            dout_d = 8'hCD;
            dval_d = 1'b1;
          end
        end
      end
      ACK2: begin
        if (inta_strobe) begin
          dval_d = 1'b1;
          if (mode_8086) begin
            dout_d   = {vector_base, lvl_q};
            last_ack = 1'b1;
            state_d  = IDLE;
          end else begin
            dout_d  = {call_addr_lo, lvl_q, 2'b00};
            state_d = ACK3;
          end
        end
      end
      ACK3: begin
        if (inta_strobe) begin
          dout_d   = call_addr_hi;
          dval_d   = 1'b1;
          last_ack = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (last_ack && auto_eoi && !spur_q) begin
      clr_v[lvl_q] = 1'b1;
      if (auto_rotate) rot_d = lvl_q;
    end

    // An explicit EOI outranks AEOI for the rotation pointer.
    if (eoi_cmd) begin
      if (eoi_specific) begin
        clr_v[eoi_level] = 1'b1;
        if (eoi_rotate) rot_d = eoi_level;
      end else begin
        for (int k = 1; k <= NUM_IRQ; k++) begin
          idx = rot_q + LVL_W'(k);
          if (!found && isr_q[idx]) begin
            found      = 1'b1;
            clr_v[idx] = 1'b1;
            if (eoi_rotate) rot_d = idx;
          end
        end
      end
    end

    isr_d = (isr_q & ~clr_v) | set_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      isr_q   <= '0;
      rot_q   <= '1;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      busy_q  <= 1'b0;
      lvl_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      isr_q   <= isr_d;
      rot_q   <= rot_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      busy_q  <= (state_d != IDLE);
      lvl_q   <= lvl_d;
      spur_q  <= spur_d;
    end
  end

  assign int_out         = int_q;
  assign isr             = isr_q;
  assign priority_rotate = rot_q;
  assign data_out        = dout_q;
  assign data_valid      = dval_q;
  assign ack_busy        = busy_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer: directed scenarios plus
// randomized INTA/EOI traffic against a level-based model.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       inta_strobe;
  logic       mode_8086;
  logic       auto_eoi;
  logic       auto_rotate;
  logic [4:0] vector_base;
  logic [2:0] call_addr_lo;
  logic [7:0] call_addr_hi;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       int_out;
  logic [7:0] isr;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_valid;
  logic       ack_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_isr;
  int         m_rot;

  interrupt_ack_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .interrupt      (interrupt),
    .inta_strobe    (inta_strobe),
    .mode_8086      (mode_8086),
    .auto_eoi       (auto_eoi),
    .auto_rotate    (auto_rotate),
    .vector_base    (vector_base),
    .call_addr_lo   (call_addr_lo),
    .call_addr_hi   (call_addr_hi),
    .eoi_cmd        (eoi_cmd),
    .eoi_specific   (eoi_specific),
    .eoi_level      (eoi_level),
    .eoi_rotate     (eoi_rotate),
    .int_out        (int_out),
    .isr            (isr),
    .priority_rotate(priority_rotate),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .ack_busy       (ack_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    inta_strobe = 1'b1;
    tick();
    inta_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_isr = 8'h00;
    m_rot = 7;
  endtask

  task automatic check_state(input string nm);
    checks++;
    if (isr !== m_isr || priority_rotate !== 3'(m_rot)) begin
      errors++;
      $display("FAIL %s: isr=%h rot=%0d, want isr=%h rot=%0d",
               nm, isr, priority_rotate, m_isr, m_rot);
    end
  endtask

  // Full INTA sequence; model computes bytes from the level served.
  task automatic run_seq(input logic is86, input logic [7:0] irq,
                         input logic withdraw, input logic aeoi,
                         input logic arot, output logic [7:0] last);
    logic [7:0] eff;
    logic [7:0] exp_b;
    int         lvl;
    mode_8086   = is86;
    auto_eoi    = aeoi;
    auto_rotate = arot;
    interrupt   = irq;
    tick();
    checks++;
    if (int_out !== 1'b1) begin
      errors++;
      $display("FAIL int_raise: int_out=%b want 1", int_out);
    end
    if (withdraw) interrupt = 8'h00;
    tick();
    eff = interrupt;
    lvl = 7;
    for (int i = 0; i < 8; i++) if (eff[i]) lvl = i;
    strobe();
    interrupt = 8'h00;
    m_isr = m_isr | eff;
    checks++;
    if (int_out !== 1'b0 || data_valid !== !is86 ||
        (!is86 && data_out !== 8'hCD)) begin
      errors++;
      $display("FAIL inta1: int=%b dv=%b do=%h want int=0 dv=%b",
               int_out, data_valid, data_out, !is86);
    end
    check_state("inta1_isr");
    tick();
    strobe();
    exp_b = is86 ? {vector_base, 3'(lvl)}
                 : {call_addr_lo, 3'(lvl), 2'b00};
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp_b) begin
      errors++;
      $display("FAIL inta2: dv=%b do=%h want dv=1 do=%h",
               data_valid, data_out, exp_b);
    end
    last = data_out;
    if (!is86) begin
      strobe();
      checks++;
      if (data_valid !== 1'b1 || data_out !== call_addr_hi) begin
        errors++;
        $display("FAIL inta3: dv=%b do=%h want dv=1 do=%h",
                 data_valid, data_out, call_addr_hi);
      end
      last = data_out;
    end
    if (aeoi && eff != 0) begin
      m_isr[lvl] = 1'b0;
      if (arot) m_rot = lvl;
    end
    check_state("seq_end");
    tick();
    checks++;
    if (data_valid !== 1'b0 || ack_busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_idle: dv=%b busy=%b want 0 0",
               data_valid, ack_busy);
    end
  endtask

  task automatic do_eoi(input logic spec, input int lvl,
                        input logic rot);
    int hit;
    eoi_cmd      = 1'b1;
    eoi_specific = spec;
    eoi_level    = 3'(lvl);
    eoi_rotate   = rot;
    tick();
    eoi_cmd = 1'b0;
    hit = -1;
    if (spec) hit = lvl;
    else
      for (int k = 1; k <= 8 && hit < 0; k++)
        if (m_isr[(m_rot + k) % 8]) hit = (m_rot + k) % 8;
    if (hit >= 0) begin
      m_isr[hit] = 1'b0;
      if (rot) m_rot = hit;
    end
    check_state("eoi");
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (int_out !== 0 || isr !== 0 || priority_rotate !== 3'd7 ||
        data_out !== 0 || data_valid !== 0 || ack_busy !== 0) begin
      errors++;
      $display("FAIL reset: int=%b isr=%h rot=%0d do=%h dv=%b bz=%b",
               int_out, isr, priority_rotate, data_out,
               data_valid, ack_busy);
    end
  endtask

  task automatic test_8086();
    logic [7:0] b;
    do_reset();
    vector_base = 5'b01000;
    run_seq(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, b);
    checks++;
    if (b !== 8'h42 || isr !== 8'h04) begin
      errors++;
      $display("FAIL t8086: do=%h isr=%h want 42 04", b, isr);
    end
  endtask

  task automatic test_aeoi_rotate();
    logic [7:0] b;
    do_reset();
    run_seq(1'b1, 8'h20, 1'b0, 1'b1, 1'b1, b);
    checks++;
    if (b !== 8'h45 || isr !== 8'h00 || priority_rotate !== 3'd5) begin
      errors++;
      $display("FAIL aeoi: do=%h isr=%h rot=%0d want 45 00 5",
               b, isr, priority_rotate);
    end
  endtask

  task automatic test_8080();
    logic [7:0] b;
    do_reset();
    call_addr_lo = 3'b101;
    call_addr_hi = 8'h12;
    run_seq(1'b0, 8'h08, 1'b0, 1'b0, 1'b0, b);
    checks++;
    if (b !== 8'h12 || isr !== 8'h08) begin
      errors++;
      $display("FAIL t8080: hi=%h isr=%h want 12 08", b, isr);
    end
  endtask

  task automatic test_spurious();
    logic [7:0] b;
    do_reset();
    run_seq(1'b1, 8'h10, 1'b1, 1'b1, 1'b1, b);
    checks++;
    if (b !== 8'h47 || isr !== 8'h00 || priority_rotate !== 3'd7) begin
      errors++;
      $display("FAIL spurious: do=%h isr=%h rot=%0d want 47 00 7",
               b, isr, priority_rotate);
    end
  endtask

  task automatic test_eoi();
    logic [7:0] b;
    do_reset();
    run_seq(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, b);
    run_seq(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, b);
    do_eoi(1'b0, 0, 1'b0);
    checks++;
    if (isr !== 8'h80) begin
      errors++;
      $display("FAIL nseoi_r7: isr=%h want 80", isr);
    end
    run_seq(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, b);
    run_seq(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, b);
    do_eoi(1'b0, 0, 1'b1);
    checks++;
    if (isr !== 8'h10 || priority_rotate !== 3'd7) begin
      errors++;
      $display("FAIL nseoi_r4: isr=%h rot=%0d want 10 7",
               isr, priority_rotate);
    end
    do_eoi(1'b0, 0, 1'b1);
    do_eoi(1'b0, 0, 1'b1);
    do_eoi(1'b1, 2, 1'b1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    mode_8086 = 1'b1;
    auto_eoi  = 1'b0;
    interrupt = 8'h04;
    tick();
    eoi_cmd      = 1'b1;
    eoi_specific = 1'b1;
    eoi_level    = 3'd2;
    eoi_rotate   = 1'b0;
    strobe();
    eoi_cmd   = 1'b0;
    interrupt = 8'h00;
    m_isr     = 8'h04;
    check_state("set_wins");
    strobe();
    checks++;
    if (data_valid !== 1'b1 || data_out !== {vector_base, 3'd2}) begin
      errors++;
      $display("FAIL simul_vec: dv=%b do=%h", data_valid, data_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode_8086 = 1'b1;
    interrupt = 8'h02;
    tick();
    strobe();
    interrupt = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_isr = 8'h00;
    m_rot = 7;
    checks++;
    if (int_out !== 0 || isr !== 0 || priority_rotate !== 3'd7 ||
        data_valid !== 0 || ack_busy !== 0) begin
      errors++;
      $display("FAIL reset_mid: int=%b isr=%h rot=%0d dv=%b bz=%b",
               int_out, isr, priority_rotate, data_valid, ack_busy);
    end
    strobe();
    checks++;
    if (data_valid !== 1'b0 || ack_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe: dv=%b bz=%b", data_valid, ack_busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      vector_base  = 5'($urandom);
      call_addr_lo = 3'($urandom);
      call_addr_hi = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        do_eoi(1'($urandom), $urandom_range(0, 7), 1'($urandom));
      else
        run_seq(1'($urandom), 8'(1 << $urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0), 1'($urandom),
                1'($urandom), b);
    end
  endtask

  initial begin
    reset        = 1'b1;
    interrupt    = 8'h00;
    inta_strobe  = 1'b0;
    mode_8086    = 1'b1;
    auto_eoi     = 1'b0;
    auto_rotate  = 1'b0;
    vector_base  = 5'b01000;
    call_addr_lo = 3'b000;
    call_addr_hi = 8'h00;
    eoi_cmd      = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
    eoi_rotate   = 1'b0;
    m_isr        = 8'h00;
    m_rot        = 7;
    tick();
    tick();
    test_reset();
    test_8086();
    test_aeoi_rotate();
    test_8080();
    test_spurious();
    test_eoi();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
